// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- decode-stage hazard detection and operand-forward selection
//
// Tracks what sits in the EX and MEM stages ({valid, dst, wr, load}).
// Each decode instruction is compared against both stages. The block then
// decides whether decode must stall and which source feeds each execute
// operand.
//
// Build option: define HAZARD_FWD_EN to enable EX/MEM and MEM/WB forwarding.
// With forwarding, only a load-use pair stalls, for one cycle.
// Without it, any RAW dependency on EX or MEM stalls. ALUsrc1/2 then read
// constant 00, because the register file is write-before-read.
//
// Parameter:
//   STALL_CNT_INIT  reset value of stall_count. Leave at 0 in normal use.
//                   A nonzero value lets the saturation path be brought up
//                   without tens of thousands of stall cycles.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   id_valid            decode-stage instruction present
//   id_src1, id_src2    source register indices
//   id_use1, id_use2    source actually read
//   id_dst              destination register index
//   id_wr               instruction writes id_dst
//   id_load             instruction is a memory load
//   flush               branch taken; decode instruction is discarded
//   stall               hold fetch/decode and the EX input registers
//   ALUsrc1, ALUsrc2    operand select: 00 regfile, 01 prev ALU, 10 prev mem
//   ex_bubble           EX slot holds a bubble
//   stall_count         saturating count of stall cycles
module hazard_ctrl #(
  parameter logic [15:0] STALL_CNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_src1,
  input  logic [2:0]  id_src2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [2:0]  id_dst,
  input  logic        id_wr,
  input  logic        id_load,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  ALUsrc1,
  output logic [1:0]  ALUsrc2,
  output logic        ex_bubble,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [2:0] dst;
    logic       wr;
    logic       load;
  } slot_t;

  typedef enum logic [1:0] {
    SRC_RF  = 2'b00,
    SRC_ALU = 2'b01,
    SRC_MEM = 2'b10
  } src_sel_e;

  // A stage produces a value the decode operand needs. Register 0 is an
  // ordinary register here, so it gets no special case.
  function automatic logic slot_match(input slot_t s, input logic use_n,
                                      input logic [2:0] src);
    return s.valid & s.wr & use_n & (s.dst == src);
  endfunction

  slot_t ex_q;
  slot_t mem_q;
  slot_t ex_d;

  logic m_ex1, m_ex2, m_mem1, m_mem2;
  logic id_live;
  logic load_ex;

  assign m_ex1  = slot_match(ex_q,  id_use1, id_src1);
  assign m_ex2  = slot_match(ex_q,  id_use2, id_src2);
  assign m_mem1 = slot_match(mem_q, id_use1, id_src1);
  assign m_mem2 = slot_match(mem_q, id_use2, id_src2);

  // flush kills the decode instruction before any hazard can hold it.
  assign id_live = id_valid & ~flush;

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded yet.
  assign stall = id_live & (m_ex1 | m_ex2) & ex_q.load;
`else
  assign stall = id_live & (m_ex1 | m_ex2 | m_mem1 | m_mem2);
`endif

  assign load_ex = id_live & ~stall;

  always_comb begin
    ex_d = '0;
    if (load_ex) begin
      ex_d.valid = 1'b1;
      ex_d.dst   = id_dst;
      ex_d.wr    = id_wr;
      ex_d.load  = id_load;
    end
  end

  // MEM always advances, including on stall and flush cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
    end
  end

  assign ex_bubble = ~ex_q.valid;

`ifdef HAZARD_FWD_EN
  src_sel_e sel1_d, sel2_d;
  src_sel_e sel1_q, sel2_q;

  // The EX match is tested first, so the newest producer wins over MEM.
  // A bubble entering EX always gets register-file selects.
  always_comb begin
    sel1_d = SRC_RF;
    sel2_d = SRC_RF;
    if (load_ex) begin
      if (m_ex1 & ~ex_q.load) sel1_d = SRC_ALU;
      else if (m_mem1)        sel1_d = SRC_MEM;
      if (m_ex2 & ~ex_q.load) sel2_d = SRC_ALU;
      else if (m_mem2)        sel2_d = SRC_MEM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel1_q <= SRC_RF;
      sel2_q <= SRC_RF;
    end else begin
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
    end
  end

  assign ALUsrc1 = sel1_q;
  assign ALUsrc2 = sel2_q;
`else
  assign ALUsrc1 = SRC_RF;
  assign ALUsrc2 = SRC_RF;
`endif

  // The MEM-stage load flag is tracked for completeness. No hazard rule
  // looks at it.
  logic unused_mem_load;
  assign unused_mem_load = mem_q.load;

  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= STALL_CNT_INIT;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset: clk (rising edge) and rst (active-low, asynchronous assert, synchronous release).
REQ-002 Ports, in order:
- clk  in  1  clock
- rst  in  1  async active-low reset
- id_valid  in  1  decode-stage instruction present
- id_src1, id_src2  in  3 each  source register indices
- id_use1, id_use2  in  1 each  source actually read
- id_dst  in  3  destination register index
- id_wr  in  1  instruction writes id_dst
- id_load  in  1  instruction is a memory load
- flush  in  1  branch taken; discard decode instruction
- stall  out  1  hold fetch/decode and the pipeline registers feeding EX
- ALUsrc1, ALUsrc2  out  2 each  execute operand selects: 00 register file, 01 prev_ALU, 10 prev_mem
- ex_bubble  out  1  execute-stage slot is a bubble
- stall_count  out  16  saturating count of stall cycles

Function
REQ-003 SHALL keep internal tracking slots EX and MEM, each holding {valid, dst, wr, load}.
REQ-004 On every clock edge: MEM <= EX, and EX <= the decode instruction, or a bubble (valid=0) when stall=1, flush=1 or id_valid=0.
REQ-005 match(S,n) = S.valid & S.wr & id_use_n & (S.dst == id_src_n).
REQ-006 With forwarding on, stall SHALL be combinational: id_valid & ~flush & (match(EX,1) | match(EX,2)) & EX.load.
REQ-007 ALUsrc_n SHALL be registered and updated only when EX is loaded with a real instruction: 01 if match(EX,n) & ~EX.load; else 10 if match(MEM,n); else 00.
REQ-008 EX/MEM forwarding SHALL take priority over MEM/WB forwarding when both match.
REQ-009 ALUsrc1 and ALUsrc2 SHALL be 00 whenever a bubble is loaded into EX.
REQ-010 ex_bubble SHALL equal ~EX.valid.
REQ-011 A load-use hazard SHALL cost exactly one stall cycle; the consumer then enters EX with select 10.
REQ-012 flush SHALL override stall: stall=0, a bubble is loaded into EX, and the MEM advance is unaffected.
REQ-013 Register index 0 SHALL be treated like any other register (no hardwired zero).
REQ-014 stall_count SHALL increment on each cycle with stall=1 and saturate at 16'hFFFF (no wrap).

Reset
REQ-015 rst=0 SHALL asynchronously clear: EX.valid=0, MEM.valid=0, ALUsrc1=ALUsrc2=00, stall_count=0. ex_bubble then reads 1 and stall reads 0.
REQ-016 Reset asserted mid-stall SHALL drop any pending hazard; after release, the first decode instruction SHALL see no hazard.

Configuration
REQ-017 Macro HAZARD_FWD_EN:
- Defined: forwarding behaviour per REQ-006 to REQ-011.
- Undefined: ALUsrc1 and ALUsrc2 SHALL be tied to 00, and stall = id_valid & ~flush & (match(EX,n) | match(MEM,n)) for either n. A dependent instruction then stalls 2 cycles behind an adjacent producer and 1 cycle behind a producer two ahead. The register file is write-before-read.

Verification
REQ-018 Required directed scenarios:
- Forwarding on. ADD r1 then ADD r2,r1,r3 back to back -> no stall; the second instruction enters EX with ALUsrc1=01, ALUsrc2=00.
- Forwarding on. LOAD r4, then ADD r5,r4,r4 -> stall=1 for exactly 1 cycle, ex_bubble=1 in the following cycle, consumer enters EX with ALUsrc1=ALUsrc2=10, stall_count=1.
- r2 written by both EX and MEM slots, consumer reads r2 -> select 01 (newest producer wins).
- LOAD r4 hazard with flush=1 in the same cycle -> stall=0, bubble into EX, stall_count unchanged.
- Macro undefined. ADD r1 then consumer of r1 -> stall=1 for 2 cycles, selects stay 00, stall_count=2.
- rst pulsed low during a load-use stall -> all outputs reach reset values immediately; stall_count preloaded to 16'hFFFE with 3 stall cycles ends at 16'hFFFF.
